riscv_alu_div_iter: RTL and testbench

Parametrised iterative integer divider/remainder unit for the EX stage. It executes ALU_DIVU, ALU_DIV, ALU_REMU and ALU_REM: op bit0 selects signed, op bit1 selects remainder. It generalises the fixed 32-bit serial divider to any even WIDTH and adds valid/ready handshakes on both sides. It also adds divide-by-zero and signed-overflow fast paths and a kill input for pipeline flush.

---
 rtl/riscv_alu_div_iter_pkg.sv | 26 ++
 rtl/riscv_alu_div_iter_step.sv | 24 ++
 rtl/riscv_alu_div_iter.sv | 127 ++++++++++++
 tb/tb_riscv_alu_div_iter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_div_iter_pkg.sv
// Shared EX-stage definitions: ALU op encodings and divider FSM/op-decode helpers.
package riscv_defines;

    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

    // Divider op field: bit0 = signed, bit1 = remainder
    localparam int DIV_OP_SIGNED_BIT = 0;
    localparam int DIV_OP_REM_BIT    = 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_FINISH
    } div_state_t;

    // True for the four divide/remainder encodings; anything else runs as DIVU
    function automatic logic div_op_valid(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/riscv_alu_div_iter_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module riscv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Partial remainder can reach 2*divisor-1, so the trial needs WIDTH+1 bits;
    // a set MSB on the difference means the subtraction went negative.
    always_comb begin
        shifted  = {rem, quo_msb};
        diff     = shifted - {1'b0, divisor};
        quo_bit  = ~diff[WIDTH];
        rem_next = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/riscv_alu_div_iter.sv
// Iterative restoring divider/remainder unit with valid/ready handshakes,
// divide-by-zero and signed-overflow fast paths, and a flush (kill) input.
module riscv_alu_div_iter
    import riscv_defines::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]        dividend_i,
    input  logic [WIDTH-1:0]        divisor_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        result_o
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic             accept, special;
    logic             in_signed, in_rem, b_zero, ovf;
    logic [WIDTH-1:0] abs_a, abs_b, spec_result;

    logic             rem_op_q, q_neg_q, r_neg_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] rem_next, quo_next;
    logic             quo_bit;

    riscv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo_msb  (quo_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .quo_bit  (quo_bit)
    );

    assign quo_next = {quo_q[WIDTH-2:0], quo_bit};

    // Operand decode and fast-path detection on the incoming request
    always_comb begin
        in_signed   = div_op_valid(op_i) && op_i[DIV_OP_SIGNED_BIT];
        in_rem      = div_op_valid(op_i) && op_i[DIV_OP_REM_BIT];
        b_zero      = (divisor_i == '0);
        ovf         = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
        abs_a       = (in_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
        abs_b       = (in_signed && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
        spec_result = '0;
        if (b_zero)
            spec_result = in_rem ? dividend_i : '1;
        else if (ovf)
            spec_result = in_rem ? '0 : MIN_NEG;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; kill overrides every transition including an accept
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        special = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (in_valid_i) begin
                    accept  = 1'b1;
                    special = b_zero || ovf;
                    state_d = special ? DIV_FINISH : DIV_BUSY;
                end
            end
            DIV_BUSY:   if (cnt_q == '0) state_d = DIV_FINISH;
            DIV_FINISH: if (out_ready_i) state_d = DIV_IDLE;
            default:    state_d = DIV_IDLE;
        endcase
        if (kill_i) begin
            state_d = DIV_IDLE;
            accept  = 1'b0;
            special = 1'b0;
        end
    end

    // Datapath: latch operands on accept, one restoring step per BUSY cycle,
    // sign-correct the selected result on the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_op_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            rem_op_q <= in_rem;
            q_neg_q  <= in_signed && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]) && !b_zero;
            r_neg_q  <= in_signed && dividend_i[WIDTH-1];
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvs_q    <= abs_b;
            cnt_q    <= CNT_W'(WIDTH-1);
            if (special) result_q <= spec_result;
        end else if (state_q == DIV_BUSY) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                if (rem_op_q) result_q <= r_neg_q ? -rem_next : rem_next;
                else          result_q <= q_neg_q ? -quo_next : quo_next;
            end
        end
    end

    assign in_ready_o  = (state_q == DIV_IDLE);
    assign out_valid_o = (state_q == DIV_FINISH);
    assign result_o    = result_q;

endmodule

// File: tb/tb_riscv_alu_div_iter.sv
// Directed self-checking bench for the iterative divider at WIDTH=32 and WIDTH=8.
module tb_riscv_alu_div_iter;
    import riscv_defines::*;

    logic clk, rst;
    int   errors = 0;
    int   checks = 0;

    // 32-bit instance signals
    logic                    kill32, iv32, ir32, ov32, ordy32;
    logic [ALU_OP_WIDTH-1:0] op32;
    logic [31:0]             a32, b32, res32;
    // 8-bit instance signals
    logic                    kill8, iv8, ir8, ov8, ordy8;
    logic [ALU_OP_WIDTH-1:0] op8;
    logic [7:0]              a8, b8, res8;

    riscv_alu_div_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .kill_i(kill32), .in_valid_i(iv32), .in_ready_o(ir32),
        .op_i(op32), .dividend_i(a32), .divisor_i(b32),
        .out_valid_o(ov32), .out_ready_i(ordy32), .result_o(res32)
    );

    riscv_alu_div_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .kill_i(kill8), .in_valid_i(iv8), .in_ready_o(ir8),
        .op_i(op8), .dividend_i(a8), .divisor_i(b8),
        .out_valid_o(ov8), .out_ready_i(ordy8), .result_o(res8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one request on the 32-bit unit, then count edges after the
    // accept edge until out_valid shows (bounded). Leaves the unit in FINISH.
    task automatic issue32(input logic [ALU_OP_WIDTH-1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Accept the result with a one-cycle out_ready pulse
    task automatic drain32();
        @(negedge clk);
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || res32 !== 32'h0) begin
            errors++;
            $display("FAIL reset32: out_valid=%b in_ready=%b result=%h, want 0/1/00000000", ov32, ir32, res32);
        end
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || res8 !== 8'h0) begin
            errors++;
            $display("FAIL reset8: out_valid=%b in_ready=%b result=%h, want 0/1/00", ov8, ir8, res8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Normal-path ops: result plus latency of WIDTH edges after accept
    task automatic test_normal();
        logic [ALU_OP_WIDTH-1:0] ops [7] = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_REM, 7'h00, ALU_DIVU};
        logic [31:0] as   [7] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd100};
        logic [31:0] bs   [7] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd7};
        logic [31:0] exps [7] = '{32'd3, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFC, 32'd14};
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue32(ops[i], as[i], bs[i], lat);
            checks++;
            if (lat !== 32) begin
                errors++;
                $display("FAIL normal_lat[%0d]: latency=%0d, want 32", i, lat);
            end
            checks++;
            if (res32 !== exps[i] || ir32 !== 1'b0) begin
                errors++;
                $display("FAIL normal_res[%0d]: result=%h in_ready=%b, want %h in_ready=0", i, res32, ir32, exps[i]);
            end
            drain32();
            checks++;
            if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
                errors++;
                $display("FAIL normal_drain[%0d]: out_valid=%b in_ready=%b, want 0/1", i, ov32, ir32);
            end
        end
    endtask

    // Divide-by-zero and signed overflow finish on the accept edge itself
    task automatic test_fast_paths();
        logic [ALU_OP_WIDTH-1:0] ops [4] = '{ALU_DIVU, ALU_REM, ALU_DIV, ALU_REM};
        logic [31:0] as   [4] = '{32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
        logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'h00000000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue32(ops[i], as[i], bs[i], lat);
            checks++;
            if (lat !== 0) begin
                errors++;
                $display("FAIL fast_lat[%0d]: edges after accept=%0d, want 0", i, lat);
            end
            checks++;
            if (res32 !== exps[i]) begin
                errors++;
                $display("FAIL fast_res[%0d]: result=%h, want %h", i, res32, exps[i]);
            end
            drain32();
        end
    endtask

    task automatic test_backpressure();
        int  lat;
        bit  bad = 0;
        issue32(ALU_DIVU, 32'd100, 32'd7, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov32 !== 1'b1 || ir32 !== 1'b0 || res32 !== 32'd14) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure: out_valid=%b in_ready=%b result=%h, want 1/0/0000000e held", ov32, ir32, res32);
        end
        drain32();
    endtask

    task automatic test_kill();
        bit seen = 0;
        int lat;
        @(negedge clk);
        op32 = ALU_DIVU; a32 = 32'd1000; b32 = 32'd3; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill32 = 1'b1;
        @(posedge clk); #1;
        kill32 = 1'b0;
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: in_ready=%b out_valid=%b, want 1/0", ir32, ov32);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ov32) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL kill_no_valid: out_valid seen=1, want 0");
        end
        // kill in the same cycle as a request drops the request
        @(negedge clk);
        op32 = ALU_DIVU; a32 = 32'd9; b32 = 32'd0; iv32 = 1'b1; kill32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0; kill32 = 1'b0;
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL kill_accept: in_ready=%b out_valid=%b, want 1/0", ir32, ov32);
        end
        issue32(ALU_DIVU, 32'd100, 32'd7, lat);
        checks++;
        if (res32 !== 32'd14 || lat !== 32) begin
            errors++;
            $display("FAIL after_kill: result=%h latency=%0d, want 0000000e/32", res32, lat);
        end
        drain32();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op32 = ALU_DIVU; a32 = 32'd50; b32 = 32'd5; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (ir32 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: in_ready=%b, want 0", ir32);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || res32 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b result=%h, want 0/1/00000000", ov32, ir32, res32);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_width8();
        logic [ALU_OP_WIDTH-1:0] ops [3] = '{ALU_DIVU, ALU_REMU, ALU_DIV};
        logic [7:0] as   [3] = '{8'hFF, 8'hFF, 8'h80};
        logic [7:0] bs   [3] = '{8'h10, 8'h10, 8'h03};
        logic [7:0] exps [3] = '{8'h0F, 8'h0F, 8'hD6};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op8 = ops[i]; a8 = as[i]; b8 = bs[i]; iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0;
            lat = 0;
            while (!ov8 && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 8 || res8 !== exps[i]) begin
                errors++;
                $display("FAIL w8[%0d]: result=%h latency=%0d, want %h/8", i, res8, lat, exps[i]);
            end
            @(negedge clk);
            ordy8 = 1'b1;
            @(posedge clk); #1;
            ordy8 = 1'b0;
        end
    endtask

    initial begin
        kill32 = 0; iv32 = 0; ordy32 = 0; op32 = '0; a32 = '0; b32 = '0;
        kill8  = 0; iv8  = 0; ordy8  = 0; op8  = '0; a8  = '0; b8  = '0;
        test_reset();
        test_normal();
        test_fast_paths();
        test_backpressure();
        test_kill();
        test_async_reset();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
